z80_bus_cycle_ctrl: RTL and testbench

//  Sequences one Z80 machine cycle per request: opcode fetch (M1), memory read/write, I/O read/write.

---
 rtl/z80_bus_cycle_ctrl.sv | 153 +++++++++++++++
 tb/tb_z80_bus_cycle_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_cycle_ctrl.sv
// Z80 machine-cycle sequencer: one request -> one M1/MEM/IO bus cycle, one clk per T-state.
// Optional refresh phase of M1 (T3/T4) enabled by defining Z80_BUS_REFRESH_EN.
module z80_bus_cycle_ctrl #(
    parameter int WAIT_LIMIT = 0,
    parameter int TCYC_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [2:0]        req_type,
    input  logic [15:0]       req_addr,
    input  logic [7:0]        req_wdata,
    input  logic [15:0]       reg_ir,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [7:0]        rdata,
    output logic [TCYC_W-1:0] tcycles,
    output logic [15:0]       addr,
    output logic [7:0]        dout,
    output logic              dout_en,
    input  logic [7:0]        din,
    input  logic              wait_n,
    output logic              m1_n,
    output logic              mreq_n,
    output logic              iorq_n,
    output logic              rd_n,
    output logic              wr_n,
    output logic              rfsh_n
);
    localparam int WCNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

    localparam logic [2:0] TY_M1   = 3'd1;
    localparam logic [2:0] TY_MRD  = 3'd2;
    localparam logic [2:0] TY_MWR  = 3'd3;
    localparam logic [2:0] TY_IORD = 3'd4;
    localparam logic [2:0] TY_IOWR = 3'd5;

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4, S_ABT} state_t;

    state_t            state, nxt;
    logic [2:0]        typ, typ_n;
    logic [TCYC_W-1:0] cnt, cnt_inc;
    logic [WCNT_W-1:0] wcnt;
    logic              type_ok, acc, lim_hit, fin_n;
    logic              is_m1, is_mrd, is_mwr, is_iord, is_iowr;
    logic              early, on_bus, late;
    logic              m1_d, mreq_d, iorq_d, rd_d, wr_d, rfsh_d, den_d;

    always_comb begin
        type_ok = (req_type >= TY_M1) && (req_type <= TY_IOWR);
        acc     = req && ready && type_ok;
        typ_n   = acc ? req_type : typ;
        lim_hit = (WAIT_LIMIT > 0) && (wcnt == WCNT_W'(WAIT_LIMIT));
        cnt_inc = (cnt == {TCYC_W{1'b1}}) ? cnt : cnt + TCYC_W'(1);

        nxt = state;
        case (state)
            S_IDLE:       nxt = acc ? S_T1 : S_IDLE;
            S_T1:         nxt = S_T2;
            // I/O cycles always insert one wait state; wait_n is then sampled in it
            S_T2:         nxt = (typ == TY_IORD || typ == TY_IOWR || !wait_n) ? S_TW : S_T3;
            S_TW:         nxt = wait_n ? S_T3 : (lim_hit ? S_ABT : S_TW);
            S_T3:         nxt = (typ == TY_M1) ? S_T4 : (acc ? S_T1 : S_IDLE);
            S_T4, S_ABT:  nxt = acc ? S_T1 : S_IDLE;
            default:      nxt = S_IDLE;
        endcase

        fin_n = (nxt == S_T3 && typ_n != TY_M1) || nxt == S_T4 || nxt == S_ABT;

        is_m1   = typ_n == TY_M1;
        is_mrd  = typ_n == TY_MRD;
        is_mwr  = typ_n == TY_MWR;
        is_iord = typ_n == TY_IORD;
        is_iowr = typ_n == TY_IOWR;
        early   = nxt == S_T1 || nxt == S_T2 || nxt == S_TW;
        on_bus  = early || nxt == S_T3;
        late    = nxt == S_T2 || nxt == S_TW || nxt == S_T3;

        m1_d   = is_m1 && early;
        mreq_d = (is_m1 && early) || ((is_mrd || is_mwr) && on_bus);
        rd_d   = (is_m1 && early) || (is_mrd && on_bus) || (is_iord && late);
        wr_d   = (is_mwr || is_iowr) && late;
        iorq_d = (is_iord || is_iowr) && late;
        den_d  = (is_mwr || is_iowr) && on_bus;
        rfsh_d = 1'b0;
`ifdef Z80_BUS_REFRESH_EN
        if (is_m1 && (nxt == S_T3 || nxt == S_T4)) rfsh_d = 1'b1;
        if (is_m1 && nxt == S_T3) mreq_d = 1'b1;
`endif
    end

    // Outputs are registered from the next state so strobes line up with the T-state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            typ     <= 3'd0;
            cnt     <= '0;
            wcnt    <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            rdata   <= 8'd0;
            tcycles <= '0;
            addr    <= 16'd0;
            dout    <= 8'd0;
            dout_en <= 1'b0;
            m1_n    <= 1'b1;
            mreq_n  <= 1'b1;
            iorq_n  <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            rfsh_n  <= 1'b1;
        end else begin
            state <= nxt;
            if (acc) begin
                typ  <= req_type;
                addr <= req_addr;
                cnt  <= TCYC_W'(1);
                if (is_mwr || is_iowr) dout <= req_wdata;
            end else begin
                if (state != S_IDLE) cnt <= cnt_inc;
`ifdef Z80_BUS_REFRESH_EN
                if (typ == TY_M1 && nxt == S_T3) addr <= reg_ir;
`endif
            end

            if (nxt == S_TW) wcnt <= (state == S_TW) ? wcnt + WCNT_W'(1) : WCNT_W'(1);

            if (typ == TY_M1 && (state == S_T2 || state == S_TW) && nxt == S_T3)
                rdata <= din;
            else if ((typ == TY_MRD || typ == TY_IORD) && state == S_T3)
                rdata <= din;

            if (fin_n) tcycles <= cnt_inc;
            done    <= fin_n;
            err     <= nxt == S_ABT;
            ready   <= nxt == S_IDLE || fin_n;
            dout_en <= den_d;
            m1_n    <= ~m1_d;
            mreq_n  <= ~mreq_d;
            iorq_n  <= ~iorq_d;
            rd_n    <= ~rd_d;
            wr_n    <= ~wr_d;
            rfsh_n  <= ~rfsh_d;
        end
    end

`ifndef Z80_BUS_REFRESH_EN
    logic unused_ir;
    assign unused_ir = ^reg_ir;
`endif
endmodule

// File: tb/tb_z80_bus_cycle_ctrl.sv
// Randomized bench for z80_bus_cycle_ctrl against a transaction-level timeline model.
// Honours Z80_BUS_REFRESH_EN when the design is built with it.
module tb_z80_bus_cycle_ctrl;
    localparam int WL   = 4;
    localparam int TCW  = 3;
    localparam int TMAX = (1 << TCW) - 1;
    localparam int NTX  = 200;
    localparam int P_IDLE = 0, P_T1 = 1, P_T2 = 2, P_TW = 3, P_T3 = 4, P_T4 = 5, P_ABT = 6;

    logic           clk, reset, req;
    logic [2:0]     req_type;
    logic [15:0]    req_addr, reg_ir, addr;
    logic [7:0]     req_wdata, rdata, dout, din;
    logic           ready, done, err, dout_en, wait_n;
    logic [TCW-1:0] tcycles;
    logic           m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;

    z80_bus_cycle_ctrl #(.WAIT_LIMIT(WL), .TCYC_W(TCW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_type(req_type), .req_addr(req_addr),
        .req_wdata(req_wdata), .reg_ir(reg_ir), .ready(ready), .done(done), .err(err),
        .rdata(rdata), .tcycles(tcycles), .addr(addr), .dout(dout), .dout_en(dout_en),
        .din(din), .wait_n(wait_n), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk, n_fail;
    logic [15:0]    exp_addr;
    logic [7:0]     exp_dout, exp_rdata, pend_val;
    logic [TCW-1:0] exp_tcyc;
    bit             pend;

    int          tt[NTX];
    int          tw[NTX];
    bit          tb2b[NTX];
    logic [15:0] ta[NTX];
    logic [15:0] tir[NTX];
    logic [7:0]  twd[NTX];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {m1_n,mreq_n,iorq_n,rd_n,wr_n,rfsh_n,dout_en} for a cycle type in a given phase.
    function automatic logic [6:0] strb_of(input int t, input int ph);
        logic m1, mq, io, rd, wr, rf, de;
        bit   bus, late;
        m1 = 1; mq = 1; io = 1; rd = 1; wr = 1; rf = 1; de = 0;
        bus  = (ph == P_T1 || ph == P_T2 || ph == P_TW || ph == P_T3);
        late = (ph == P_T2 || ph == P_TW || ph == P_T3);
        case (t)
            1: begin
                if (ph == P_T1 || ph == P_T2 || ph == P_TW) begin m1 = 0; mq = 0; rd = 0; end
`ifdef Z80_BUS_REFRESH_EN
                if (ph == P_T3 || ph == P_T4) rf = 0;
                if (ph == P_T3) mq = 0;
`endif
            end
            2: if (bus) begin mq = 0; rd = 0; end
            3: begin if (bus) begin mq = 0; de = 1; end if (late) wr = 0; end
            4: if (late) begin io = 0; rd = 0; end
            5: begin if (late) begin io = 0; wr = 0; end if (bus) de = 1; end
            default: ;
        endcase
        return {m1, mq, io, rd, wr, rf, de};
    endfunction

    function automatic logic [2:0] bad_type();
        int v;
        v = $urandom_range(0, 2);
        return (v == 0) ? 3'd0 : 3'(v + 5);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (pend) begin exp_rdata = pend_val; pend = 0; end
    endtask

    task automatic check_state(input int t, input int ph, input bit fin);
        chk("strobes", 32'({m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, dout_en}), 32'(strb_of(t, ph)));
        chk("addr", 32'(addr), 32'(exp_addr));
        chk("dout", 32'(dout), 32'(exp_dout));
        chk("rdata", 32'(rdata), 32'(exp_rdata));
        chk("tcycles", 32'(tcycles), 32'(exp_tcyc));
        chk("done", 32'(done), 32'(fin));
        chk("err", 32'(err), 32'(ph == P_ABT));
        chk("ready", 32'(ready), 32'(fin || ph == P_IDLE));
    endtask

    task automatic drive_txn(input int i);
        req = 1'b1; req_type = 3'(tt[i]); req_addr = ta[i]; req_wdata = twd[i]; reg_ir = tir[i];
    endtask

    task automatic drive_garbage(input bit any_type);
        req       = 1'($urandom);
        req_type  = any_type ? 3'($urandom) : bad_type();
        req_addr  = 16'($urandom);
        req_wdata = 8'($urandom);
    endtask

    // One transaction: the timeline is T1,T2, the wait states, then T3 (+T4 for M1),
    // or an abort after WL waits; wait_n is low for the first tw[i] sampling points.
    task automatic run(input int i);
        int t, ntw, z;
        bit io, fin;
        int ph[$];
        t   = tt[i];
        io  = (t == 4 || t == 5);
        ntw = io ? tw[i] + 1 : tw[i];
        z   = 0;
        ph.push_back(P_T1);
        ph.push_back(P_T2);
        if (ntw > WL) begin
            repeat (WL) ph.push_back(P_TW);
            ph.push_back(P_ABT);
        end else begin
            repeat (ntw) ph.push_back(P_TW);
            ph.push_back(P_T3);
            if (t == 1) ph.push_back(P_T4);
        end
        for (int k = 0; k < ph.size(); k++) begin
            fin = (k == ph.size() - 1);
            step();
            if (ph[k] == P_T1) begin
                exp_addr = ta[i];
                if (t == 3 || t == 5) exp_dout = twd[i];
            end
`ifdef Z80_BUS_REFRESH_EN
            if (t == 1 && ph[k] == P_T3) exp_addr = tir[i];
`endif
            if (fin) exp_tcyc = TCW'((ph.size() > TMAX) ? TMAX : ph.size());
            check_state(t, ph[k], fin);
            if (ph[k] == P_TW || (ph[k] == P_T2 && !io)) begin
                wait_n = (z < tw[i]) ? 1'b0 : 1'b1;
                z++;
            end else begin
                wait_n = 1'($urandom);
            end
            din = 8'($urandom);
            if ((t == 1 && !fin && ph[k+1] == P_T3) || ((t == 2 || t == 4) && ph[k] == P_T3)) begin
                pend = 1; pend_val = din;
            end
            if (!fin) drive_garbage(1'b1);
            else if (i + 1 < NTX && tb2b[i+1]) drive_txn(i + 1);
            else drive_garbage(1'b0);
        end
    endtask

    initial begin
        int g;
        n_chk = 0; n_fail = 0;
        reset = 1'b1; req = 1'b0; req_type = 3'd0; req_addr = 16'd0; req_wdata = 8'd0;
        reg_ir = 16'd0; din = 8'd0; wait_n = 1'b1;
        exp_addr = 0; exp_dout = 0; exp_rdata = 0; exp_tcyc = 0; pend = 0; pend_val = 0;

        // directed: spec scenarios, abort, tcycles saturation, back-to-back
        tt[0] = 3; ta[0] = 16'h1234; twd[0] = 8'hA5; tw[0] = 0; tb2b[0] = 0;
        tt[1] = 1; ta[1] = 16'h0100; twd[1] = 8'h00; tw[1] = 2; tb2b[1] = 0;
        tt[2] = 4; ta[2] = 16'h00FE; twd[2] = 8'h00; tw[2] = 0; tb2b[2] = 0;
        tt[3] = 1; ta[3] = 16'h0200; twd[3] = 8'h00; tw[3] = 0; tb2b[3] = 0;
        tt[4] = 3; ta[4] = 16'h3000; twd[4] = 8'h3C; tw[4] = 0; tb2b[4] = 1;
        tt[5] = 2; ta[5] = 16'h5555; twd[5] = 8'h00; tw[5] = 5; tb2b[5] = 0;
        tt[6] = 1; ta[6] = 16'h0400; twd[6] = 8'h00; tw[6] = 4; tb2b[6] = 0;
        tt[7] = 5; ta[7] = 16'h00AA; twd[7] = 8'h11; tw[7] = 1; tb2b[7] = 1;
        for (int i = 0; i < NTX; i++) begin
            tir[i] = 16'($urandom);
            if (i >= 8) begin
                tt[i]   = $urandom_range(1, 5);
                ta[i]   = 16'($urandom);
                twd[i]  = 8'($urandom);
                tw[i]   = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 5) : $urandom_range(0, 2);
                tb2b[i] = 1'($urandom);
            end
        end

        #1;
        check_state(0, P_IDLE, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NTX; i++) begin
            if (!tb2b[i]) begin
                g = $urandom_range(1, 3);
                repeat (g) begin
                    step();
                    check_state(0, P_IDLE, 1'b0);
                    drive_garbage(1'b0);
                end
                drive_txn(i);
            end
            run(i);
        end

        // async reset in the wait state of a memory write
        step();
        check_state(0, P_IDLE, 1'b0);
        req = 1'b1; req_type = 3'd3; req_addr = 16'h4321; req_wdata = 8'h5A; wait_n = 1'b0;
        step();
        req = 1'b0;
        step();
        step();
        chk("pre_reset_strobes", 32'({mreq_n, wr_n, dout_en}), 32'(3'b001));
        #2;
        reset = 1'b1;
        #1;
        chk("reset_strobes", 32'({m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, dout_en}), 32'(7'b1111110));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_ready", 32'(ready), 32'(1));
        chk("reset_addr", 32'(addr), 32'(0));
        exp_addr = 0; exp_dout = 0; exp_rdata = 0; exp_tcyc = 0; pend = 0;
        @(negedge clk);
        reset = 1'b0; wait_n = 1'b1;
        step();
        check_state(0, P_IDLE, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
